// File: rtl/fir_pkg.sv
// Shared register map, state encodings and arbiter defaults for the FIR AP controller.
package fir_pkg;

    localparam int ADDR_AP_CTRL   = 'h00;
    localparam int ADDR_DATA_LEN  = 'h10;
    localparam int ADDR_TAP_BASE  = 'h20;
    localparam int STARVE_LIM_DEF = 16;

    typedef enum logic [1:0] {
        AP_IDLE  = 2'd0,
        AP_START = 2'd1,
        AP_RUN   = 2'd2
    } ap_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fir_tap_arb.sv
// Tap RAM arbiter: engine > AXI write > AXI read, with a starvation counter that
// forces one AXI grant after STARVE_LIM consecutive waiting cycles.
module fir_tap_arb
    import fir_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic axis_clk,
    input  logic axis_rst_n,
    input  logic eng_req,
    input  logic wr_req,
    input  logic rd_req,
    output logic eng_gnt,
    output logic wr_gnt,
    output logic rd_gnt
);

    localparam int CW = $clog2(STARVE_LIM + 1);

    logic [CW-1:0] starve_cnt;
    logic          axi_req;
    logic          force_axi;

    assign axi_req   = wr_req | rd_req;
    assign force_axi = axi_req && (starve_cnt == CW'(STARVE_LIM));
    assign eng_gnt   = eng_req & ~force_axi;
    assign wr_gnt    = wr_req & ~eng_gnt;
    assign rd_gnt    = rd_req & ~eng_gnt & ~wr_req;

    // Counts only cycles where an AXI access is pending and denied.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n)
            starve_cnt <= '0;
        else if (!axi_req || force_axi || wr_gnt || rd_gnt)
            starve_cnt <= '0;
        else
            starve_cnt <= starve_cnt + CW'(1);
    end

endmodule

// File: rtl/fir_ap_ctrl.sv
// FIR AP controller: AXI-Lite register/tap access, ap_ctrl sequencing, tap RAM muxing.
//   ap state | meaning                    rd state | meaning
//   AP_IDLE  | waiting for start          R_IDLE   | waiting for arvalid (and tap grant)
//   AP_START | started, no input beat yet R_WAIT   | BRAM latency cycle, rdata captured
//   AP_RUN   | streaming until y count    R_DATA   | rvalid held until rready
module fir_ap_ctrl
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int TAP_NUM     = 11,
    parameter int STARVE_LIM  = STARVE_LIM_DEF
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    input  logic                   wvalid,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic [pDATA_WIDTH-1:0] wdata,
    output logic                   awready,
    output logic                   wready,
    input  logic                   arvalid,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   arready,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   eng_tap_req,
    input  logic [pADDR_WIDTH-1:0] eng_tap_addr,
    output logic                   eng_tap_gnt,
    input  logic                   ss_beat,
    input  logic                   y_beat,
    output logic                   eng_start,
    output logic [pDATA_WIDTH-1:0] data_length,
    output logic                   ap_start,
    output logic                   ap_done,
    output logic                   ap_idle,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    input  logic [pDATA_WIDTH-1:0] tap_Do
);

    localparam logic [pADDR_WIDTH-1:0] A_CTRL = pADDR_WIDTH'(ADDR_AP_CTRL);
    localparam logic [pADDR_WIDTH-1:0] A_LEN  = pADDR_WIDTH'(ADDR_DATA_LEN);
    localparam logic [pADDR_WIDTH-1:0] A_TAP0 = pADDR_WIDTH'(ADDR_TAP_BASE);
    localparam logic [pADDR_WIDTH-1:0] A_TAPN = pADDR_WIDTH'(ADDR_TAP_BASE + 4*TAP_NUM - 4);

    ap_state_t              ap_state, ap_next;
    rd_state_t              rd_state, rd_next;
    logic [pADDR_WIDTH-1:0] rd_addr;
    logic [pDATA_WIDTH-1:0] ss_cnt, y_cnt;
    logic                   wr_is_tap, rd_is_tap, wr_req, rd_req, wr_gnt, rd_gnt;
    logic                   wr_fire, r_fire, start_go, done_set;

    assign wr_is_tap = (awaddr >= A_TAP0) && (awaddr <= A_TAPN);
    assign rd_is_tap = (araddr >= A_TAP0) && (araddr <= A_TAPN);

    // Tap writes outside IDLE are swallowed without touching the RAM, so they never arbitrate.
    assign wr_req  = awvalid & wvalid & wr_is_tap & (ap_state == AP_IDLE);
    assign rd_req  = (rd_state == R_IDLE) & arvalid & rd_is_tap;
    assign awready = awvalid & wvalid & (~wr_req | wr_gnt);
    assign wready  = awready;
    assign wr_fire = awready;
    assign arready = (rd_state == R_IDLE) & arvalid & (~rd_req | rd_gnt);
    assign rvalid  = (rd_state == R_DATA);
    assign r_fire  = rvalid & rready;

    assign ap_idle  = (ap_state == AP_IDLE);
    assign ap_start = (ap_state == AP_START);
    assign start_go = ap_idle & wr_fire & (awaddr == A_CTRL) & wdata[0] & (data_length != '0);

    fir_tap_arb #(.STARVE_LIM(STARVE_LIM)) u_arb (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .eng_req    (eng_tap_req),
        .wr_req     (wr_req),
        .rd_req     (rd_req),
        .eng_gnt    (eng_tap_gnt),
        .wr_gnt     (wr_gnt),
        .rd_gnt     (rd_gnt)
    );

    always_comb begin
        tap_EN = eng_tap_gnt | wr_gnt | rd_gnt;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (eng_tap_gnt) begin
            tap_A = eng_tap_addr;
        end else if (wr_gnt) begin
            tap_WE = 4'hF;
            tap_A  = awaddr - A_TAP0;
            tap_Di = wdata;
        end else if (rd_gnt) begin
            tap_A = araddr - A_TAP0;
        end
    end

    always_comb begin
        ap_next  = ap_state;
        done_set = 1'b0;
        case (ap_state)
            AP_IDLE:  if (start_go) ap_next = AP_START;
            AP_START: if (ss_beat) ap_next = AP_RUN;
            AP_RUN: begin
                if (y_beat && ((y_cnt + pDATA_WIDTH'(1)) >= data_length)) begin
                    ap_next  = AP_IDLE;
                    done_set = 1'b1;
                end
            end
            default:  ap_next = AP_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            ap_state    <= AP_IDLE;
            ap_done     <= 1'b0;
            eng_start   <= 1'b0;
            data_length <= '0;
            ss_cnt      <= '0;
            y_cnt       <= '0;
        end else begin
            ap_state  <= ap_next;
            eng_start <= start_go;
            if (start_go) begin
                ss_cnt <= '0;
                y_cnt  <= '0;
            end else if (!ap_idle) begin
                if (ss_beat && (ss_cnt < data_length)) ss_cnt <= ss_cnt + pDATA_WIDTH'(1);
                if (y_beat) y_cnt <= y_cnt + pDATA_WIDTH'(1);
            end
            if (ap_idle && wr_fire && (awaddr == A_LEN)) data_length <= wdata;
            // A done set wins over a same-cycle read-clear.
            if (start_go)
                ap_done <= 1'b0;
            else if (done_set)
                ap_done <= 1'b1;
            else if (r_fire && (rd_addr == A_CTRL))
                ap_done <= 1'b0;
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (arready) rd_next = R_WAIT;
            R_WAIT:  rd_next = R_DATA;
            R_DATA:  if (rready) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            rd_state <= R_IDLE;
            rd_addr  <= '0;
            rdata    <= '0;
        end else begin
            rd_state <= rd_next;
            if (arready) rd_addr <= araddr;
            if (rd_state == R_WAIT) begin
                if (rd_addr == A_CTRL)
                    rdata <= pDATA_WIDTH'({ap_idle, ap_done, ap_start});
                else if (rd_addr == A_LEN)
                    rdata <= data_length;
                else if ((rd_addr >= A_TAP0) && (rd_addr <= A_TAPN))
                    rdata <= tap_Do;
                else
                    rdata <= '1;
            end
        end
    end

endmodule

// File: tb/tb_fir_ap_ctrl.sv
// Self-checking bench for fir_ap_ctrl: behavioural tap BRAM, tap/register model, randomized runs.
module tb_fir_ap_ctrl;

    localparam int TAP_NUM = 11;
    localparam int STARVE  = 16;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n;
    logic        awvalid, wvalid, awready, wready;
    logic [11:0] awaddr;
    logic [31:0] wdata;
    logic        arvalid, arready, rvalid, rready;
    logic [11:0] araddr;
    logic [31:0] rdata;
    logic        eng_tap_req, eng_tap_gnt;
    logic [11:0] eng_tap_addr;
    logic        ss_beat, y_beat, eng_start;
    logic [31:0] data_length;
    logic        ap_start, ap_done, ap_idle;
    logic [3:0]  tap_WE;
    logic        tap_EN;
    logic [11:0] tap_A;
    logic [31:0] tap_Di;
    logic [31:0] tap_Do;

    int          tests = 0;
    int          fails = 0;
    int          n_start = 0;
    logic [31:0] bram [TAP_NUM];
    logic [31:0] model_tap [TAP_NUM];
    logic [31:0] model_len;

    always #5 axis_clk = ~axis_clk;

    fir_ap_ctrl dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awvalid(awvalid), .wvalid(wvalid), .awaddr(awaddr), .wdata(wdata),
        .awready(awready), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .eng_tap_req(eng_tap_req), .eng_tap_addr(eng_tap_addr), .eng_tap_gnt(eng_tap_gnt),
        .ss_beat(ss_beat), .y_beat(y_beat), .eng_start(eng_start), .data_length(data_length),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_A(tap_A), .tap_Di(tap_Di), .tap_Do(tap_Do)
    );

    // Tap BRAM with one-cycle read latency.
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF && int'(tap_A[11:2]) < TAP_NUM) bram[tap_A[11:2]] <= tap_Di;
            tap_Do <= (int'(tap_A[11:2]) < TAP_NUM) ? bram[tap_A[11:2]] : 32'h0;
        end
    end

    always @(negedge axis_clk) if (eng_start) n_start++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        axis_rst_n = 1'b0;
        awvalid = 0; wvalid = 0; awaddr = '0; wdata = '0;
        arvalid = 0; araddr = '0; rready = 0;
        eng_tap_req = 0; eng_tap_addr = '0; ss_beat = 0; y_beat = 0;
        model_len = '0;
        repeat (3) @(negedge axis_clk);
        axis_rst_n = 1'b1;
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
        bit ok = 0;
        @(negedge axis_clk);
        awvalid = 1; wvalid = 1; awaddr = a; wdata = d;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (awready && wready) begin ok = 1; break; end
            @(negedge axis_clk);
        end
        @(negedge axis_clk);
        awvalid = 0; wvalid = 0;
        tests++;
        if (!ok) begin fails++; $display("FAIL write_accept addr=%h: awready never seen, required within 100 cycles", a); end
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output int lat);
        bit ok = 0;
        d = '0; lat = -1;
        @(negedge axis_clk);
        arvalid = 1; araddr = a; rready = 1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (arready) begin ok = 1; break; end
            @(negedge axis_clk);
        end
        @(negedge axis_clk);
        arvalid = 0;
        if (ok) begin
            ok = 0;
            for (int i = 1; i < 10; i++) begin
                #1;
                if (rvalid) begin ok = 1; lat = i; d = rdata; break; end
                @(negedge axis_clk);
            end
        end
        @(negedge axis_clk);
        rready = 0;
        tests++;
        if (!ok) begin fails++; $display("FAIL read_handshake addr=%h: no arready/rvalid, required within budget", a); end
    endtask

    task automatic pulse(input bit is_y);
        @(negedge axis_clk);
        if (is_y) y_beat = 1; else ss_beat = 1;
        @(negedge axis_clk);
        y_beat = 0; ss_beat = 0;
        repeat ($urandom_range(0, 2)) @(negedge axis_clk);
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        tests++;
        if ({ap_idle, ap_start, ap_done, rvalid, eng_start, tap_EN, tap_WE} !== 10'b1000000000) begin
            fails++;
            $display("FAIL reset_status got idle/start/done/rvalid/eng_start/EN/WE=%b required 1000000000",
                     {ap_idle, ap_start, ap_done, rvalid, eng_start, tap_EN, tap_WE});
        end
        tests++;
        if (data_length !== 32'h0) begin fails++; $display("FAIL reset_len got %h required 0", data_length); end
        tests++;
        if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h required 0", rdata); end
    endtask

    task automatic test_zero_len();
        int n0 = n_start;
        axi_write(12'h000, 32'h1);
        repeat (3) @(negedge axis_clk);
        tests++;
        if (ap_idle !== 1'b1 || ap_start !== 1'b0) begin
            fails++; $display("FAIL zero_len_idle got idle=%b start=%b required idle=1 start=0", ap_idle, ap_start);
        end
        tests++;
        if (n_start !== n0) begin fails++; $display("FAIL zero_len_eng_start got %0d pulses required 0", n_start - n0); end
    endtask

    task automatic test_tap_rw(input bit rnd);
        logic [31:0] d;
        int          lat;
        for (int i = 0; i < TAP_NUM; i++) begin
            model_tap[i] = rnd ? $urandom : 32'(i + 1);
            axi_write(12'(32 + 4 * i), model_tap[i]);
        end
        for (int i = 0; i < TAP_NUM; i++) begin
            axi_read(12'(32 + 4 * i), d, lat);
            tests++;
            if (d !== model_tap[i]) begin fails++; $display("FAIL tap_read[%0d] got %h required %h", i, d, model_tap[i]); end
            tests++;
            if (lat !== 2) begin fails++; $display("FAIL tap_read_latency[%0d] got %0d required 2", i, lat); end
        end
    endtask

    task automatic test_misc_reads();
        logic [31:0] d;
        int          lat;
        axi_read(12'h010, d, lat);
        tests++;
        if (d !== model_len) begin fails++; $display("FAIL read_len got %h required %h", d, model_len); end
        axi_read(12'h004, d, lat);
        tests++;
        if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL read_unmapped_04 got %h required ffffffff", d); end
        axi_read(12'(32 + 4 * TAP_NUM), d, lat);
        tests++;
        if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL read_past_taps got %h required ffffffff", d); end
    endtask

    task automatic test_run(input int len, input bit write_in_run);
        logic [31:0] d;
        int          lat;
        int          n0 = n_start;
        pulse(1'b1);
        axi_write(12'h010, 32'(len));
        model_len = 32'(len);
        tests++;
        if (data_length !== model_len) begin fails++; $display("FAIL run_len got %h required %h", data_length, model_len); end
        axi_write(12'h000, 32'h1);
        #1;
        tests++;
        if ({ap_idle, ap_start, ap_done} !== 3'b010) begin
            fails++; $display("FAIL run_started got idle/start/done=%b required 010", {ap_idle, ap_start, ap_done});
        end
        for (int i = 0; i < len + 2; i++) pulse(1'b0);
        if (write_in_run) begin
            axi_write(12'h020, 32'hAA);
            axi_write(12'h010, 32'h7);
            tests++;
            if (data_length !== model_len) begin fails++; $display("FAIL run_len_locked got %h required %h", data_length, model_len); end
        end
        for (int i = 0; i < len; i++) begin
            @(negedge axis_clk);
            #1;
            tests++;
            if (ap_idle !== 1'b0) begin fails++; $display("FAIL run_busy beat %0d got idle=%b required 0", i, ap_idle); end
            y_beat = 1;
            @(negedge axis_clk);
            y_beat = 0;
        end
        #1;
        tests++;
        if ({ap_idle, ap_done} !== 2'b11) begin
            fails++; $display("FAIL run_done got idle/done=%b required 11", {ap_idle, ap_done});
        end
        tests++;
        if (n_start !== n0 + 1) begin fails++; $display("FAIL run_eng_start got %0d pulses required 1", n_start - n0); end
        pulse(1'b1);
        axi_read(12'h000, d, lat);
        tests++;
        if (d !== 32'h6) begin fails++; $display("FAIL ctrl_read_done got %h required 6", d); end
        axi_read(12'h000, d, lat);
        tests++;
        if (d !== 32'h4) begin fails++; $display("FAIL ctrl_read_cleared got %h required 4", d); end
        if (write_in_run) begin
            axi_read(12'h020, d, lat);
            tests++;
            if (d !== model_tap[0]) begin fails++; $display("FAIL run_tap_locked got %h required %h", d, model_tap[0]); end
        end
    endtask

    task automatic test_starve();
        logic [31:0] d = '0;
        int          low_cnt = 0;
        int          low_at = -1;
        bit          got = 0;
        bit          drop = 0;
        @(negedge axis_clk);
        eng_tap_req = 1; eng_tap_addr = 12'h000;
        arvalid = 1; araddr = 12'h02C; rready = 1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!eng_tap_gnt) begin low_cnt++; if (low_at < 0) low_at = c; end
            if (arvalid && arready) drop = 1;
            if (rvalid && !got) begin got = 1; d = rdata; end
            @(negedge axis_clk);
            if (drop) begin arvalid = 0; drop = 0; end
        end
        eng_tap_req = 0; arvalid = 0; rready = 0;
        tests++;
        if (low_at !== STARVE) begin fails++; $display("FAIL starve_when gnt dropped at cycle %0d required %0d", low_at, STARVE); end
        tests++;
        if (low_cnt !== 1) begin fails++; $display("FAIL starve_width gnt low %0d cycles required 1", low_cnt); end
        tests++;
        if (!got || d !== model_tap[3]) begin fails++; $display("FAIL starve_rdata got %h (seen=%0b) required %h", d, got, model_tap[3]); end
    endtask

    task automatic test_reset_mid_run();
        axi_write(12'h010, 32'h5);
        axi_write(12'h000, 32'h1);
        pulse(1'b0);
        pulse(1'b1);
        @(negedge axis_clk);
        axis_rst_n = 1'b0;
        model_len = '0;
        #1;
        tests++;
        if ({ap_idle, ap_start, ap_done, rvalid, eng_start, tap_EN, tap_WE} !== 10'b1000000000) begin
            fails++;
            $display("FAIL midrun_reset_status got %b required 1000000000",
                     {ap_idle, ap_start, ap_done, rvalid, eng_start, tap_EN, tap_WE});
        end
        tests++;
        if (data_length !== 32'h0 || rdata !== 32'h0) begin
            fails++; $display("FAIL midrun_reset_regs got len=%h rdata=%h required 0/0", data_length, rdata);
        end
        repeat (2) @(negedge axis_clk);
        axis_rst_n = 1'b1;
        repeat (3) @(negedge axis_clk);
        tests++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
            fails++; $display("FAIL midrun_after got idle=%b done=%b required 1/0", ap_idle, ap_done);
        end
    endtask

    initial begin
        for (int i = 0; i < TAP_NUM; i++) bram[i] = '0;
        test_reset();
        test_zero_len();
        test_tap_rw(1'b0);
        test_misc_reads();
        test_tap_rw(1'b1);
        test_run(4, 1'b0);
        for (int k = 0; k < 3; k++) test_run(int'($urandom_range(1, 6)), 1'b0);
        test_misc_reads();
        test_run(3, 1'b1);
        test_starve();
        test_reset_mid_run();
        test_misc_reads();
        test_tap_rw(1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_ap_ctrl.md
FIR_AP_CTRL -- requirements
Module: fir_ap_ctrl

Interface
REQ-001 SHALL have parameters: pADDR_WIDTH, 12, AXI-Lite/BRAM address width; pDATA_WIDTH, 32, data width; TAP_NUM, 11, coefficient count; STARVE_LIM, 16, AXI wait cycles before forced grant.
REQ-002 SHALL have ports, one per line:
axis_clk  in  1  clock
axis_rst_n  in  1  reset, asynchronous, active-low
awvalid/wvalid  in  1 each  AXI-Lite write address/data valid
awaddr  in  pADDR_WIDTH  write address
wdata  in  pDATA_WIDTH  write data
awready/wready  out  1 each  write accept
arvalid  in  1  read address valid
araddr  in  pADDR_WIDTH  read address
arready  out  1  read address accept
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  pDATA_WIDTH  read data
eng_tap_req  in  1  engine tap-RAM read request
eng_tap_addr  in  pADDR_WIDTH  engine tap byte address
eng_tap_gnt  out  1  engine granted tap RAM this cycle
ss_beat  in  1  input stream beat accepted
y_beat  in  1  output stream beat accepted
eng_start  out  1  one-cycle engine start pulse
data_length  out  pDATA_WIDTH  programmed sample count
ap_start/ap_done/ap_idle  out  1 each  status bits
tap_WE  out  4  tap BRAM byte write enable
tap_EN  out  1  tap BRAM enable
tap_A  out  pADDR_WIDTH  tap BRAM byte address
tap_Di  out  pDATA_WIDTH  tap BRAM write data
tap_Do  in  pDATA_WIDTH  tap BRAM read data, 1-cycle latency

Function
REQ-003 SHALL map 0x00 ap_ctrl {29'b0, ap_idle[2], ap_done[1], ap_start[0]}; 0x10 data_length; 0x20..0x20+4*TAP_NUM-4 taps (tap_A = addr-0x20); other reads return 0xFFFFFFFF, other writes dropped.
REQ-004 SHALL accept a write only when awvalid&wvalid both high: awready=wready=1 that cycle, effect applied next edge, no response channel.
REQ-005 SHALL run read FSM R_IDLE->(arvalid, arready=1, latch araddr)->R_WAIT(1 cycle, BRAM access if tap)->R_DATA(rvalid=1 until rready)->R_IDLE; R_IDLE SHALL hold in place while a tap read is not granted.
REQ-006 SHALL run ap FSM IDLE->START->RUN->IDLE; ap_idle=1 only in IDLE, ap_start=1 only in START.
REQ-007 IDLE: write 0x00 with wdata[0]=1 and data_length!=0 SHALL enter START, pulse eng_start, clear ap_done, clear ss/y counters; data_length==0 SHALL ignore start.
REQ-008 START SHALL move to RUN on first ss_beat; RUN SHALL move to IDLE and set ap_done when y_count reaches data_length (y_beat counted that cycle).
REQ-009 ss_beat beyond data_length SHALL be ignored; y_beat in IDLE SHALL be ignored.
REQ-010 ap_done SHALL clear on rvalid&rready of a 0x00 read; set and clear same cycle SHALL leave ap_done=1.
REQ-011 Writes to 0x10 or taps outside IDLE SHALL be accepted and discarded; writes to 0x00 outside IDLE SHALL be ignored.
REQ-012 Tap RAM arbiter priority: engine > AXI write > AXI read; AXI tap write SHALL stall (awready=0) while not granted.
REQ-013 Starvation counter SHALL count consecutive cycles an AXI tap access waits; at STARVE_LIM it SHALL grant AXI one cycle with eng_tap_gnt=0, then reset to 0.
REQ-014 tap_EN SHALL equal any grant; tap_WE=4'hF only on AXI write grant.

Reset
REQ-015 Reset SHALL give: ap FSM IDLE, ap_idle=1, ap_start=0, ap_done=0, data_length=0, read FSM R_IDLE, rvalid=0, rdata=0, eng_start=0, starvation counter 0, tap_WE=0, tap_EN=0.
REQ-016 Reset mid-RUN SHALL return to IDLE next cycle with no ap_done.

Structure
REQ-017 Register offsets, FSM state encodings and STARVE_LIM default SHALL live in shared package fir_pkg.
REQ-018 Tap arbiter with starvation counter SHALL be sub-module fir_tap_arb.

Verification
REQ-019 Write taps 0..10 = 1..11 in IDLE, read back -> rdata 1..11, rvalid one cycle after R_WAIT.
REQ-020 data_length=0, write 0x00=1 -> ap_idle stays 1, no eng_start.
REQ-021 data_length=4, start, 4 ss_beat, 4 y_beat -> ap_idle=0 until 4th y_beat, then ap_done=1, ap_idle=1; read 0x00 -> 0x6 then 0x4.
REQ-022 eng_tap_req held high 40 cycles, AXI tap read pending -> eng_tap_gnt drops exactly one cycle after 16 waits, rdata correct.
REQ-023 In RUN write tap0=0xAA and 0x10=7 -> readback unchanged, data_length unchanged.
REQ-024 Assert reset mid-RUN -> all REQ-015 values, ap_done=0.
